// File: rtl/uart_baud_gen_pkg.sv
// Shared types, baud table and divisor/increment helpers for the UART baud-tick generator.
package uart_baud_pkg;

  typedef logic [2:0] baud_sel_t;

  localparam int unsigned BAUD_TABLE [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};

  // Round-half-up of clk_hz / (baud*ovs), done exactly as floor((2*clk + d) / (2*d)).
  function automatic logic [63:0] div_of(input baud_sel_t sel, input logic [63:0] clk_hz,
                                         input logic [63:0] ovs);
    logic [63:0] d;
    d = 64'(BAUD_TABLE[sel]) * ovs;
    return (2 * clk_hz + d) / (2 * d);
  endfunction

  // Phase increment round(2^acc_w * baud*ovs / clk_hz), same rounding trick.
  function automatic logic [63:0] inc_of(input baud_sel_t sel, input logic [63:0] clk_hz,
                                         input logic [63:0] ovs, input int unsigned acc_w);
    logic [63:0] d;
    d = 64'(BAUD_TABLE[sel]) * ovs;
    return ((d << (acc_w + 1)) + clk_hz) / (2 * clk_hz);
  endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Control/strobe bundle between the baud generator (slave) and its UART user (master).
interface uart_baud_gen_if
  import uart_baud_pkg::*;
#(
  parameter int OVERSAMPLE = 16
);
  localparam int PH_W = $clog2(OVERSAMPLE);

  logic            enable;
  baud_sel_t       baud_select;
  logic            sample_ENABLE;
  logic            tx_ENABLE;
  logic [PH_W-1:0] bit_phase;

  modport master (output enable, baud_select, input sample_ENABLE, tx_ENABLE, bit_phase);
  modport slave  (input enable, baud_select, output sample_ENABLE, tx_ENABLE, bit_phase);
endinterface

// File: rtl/uart_baud_gen_div.sv
// baud_tick_div: 1-cycle tick source. Integer terminal-count divider by default;
// phase accumulator (carry = tick) when UART_BAUD_FRAC_EN is defined.
module baud_tick_div
  import uart_baud_pkg::*;
#(
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              run_i,
  input  logic [STEP_W-1:0] step_i,
  output logic              tick_o
);

`ifdef UART_BAUD_FRAC_EN
  logic [STEP_W-1:0] acc_q, acc_d;
  logic              carry;

  always_comb begin
    tick_o = 1'b0;
    carry  = 1'b0;
    acc_d  = '0;
    if (run_i && !clr_i) begin
      {carry, acc_d} = {1'b0, acc_q} + {1'b0, step_i};
      tick_o         = carry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end
`else
  // step_i is the terminal count (divisor - 1).
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              hit;

  always_comb begin
    hit   = 1'b0;
    cnt_d = '0;
    if (run_i && !clr_i) begin
      hit   = (cnt_q == step_i);
      cnt_d = hit ? '0 : cnt_q + 1'b1;
    end
    tick_o = hit;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`endif

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud-tick generator: registered oversample/bit strobes from an 8-entry baud table.
// Define UART_BAUD_FRAC_EN for the fractional phase-accumulator divider.
module uart_baud_gen
  import uart_baud_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned ACC_W      = 24
) (
  input  logic           clk,
  input  logic           reset,
  uart_baud_gen_if.slave bus
);

  localparam int PH_W = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
`ifdef UART_BAUD_FRAC_EN
  localparam int STEP_W = ACC_W;
`else
  localparam int STEP_W = CNT_W;
`endif

  typedef logic [7:0][STEP_W-1:0] step_tbl_t;

  function automatic step_tbl_t build_tbl();
    step_tbl_t tbl;
    tbl = '0;
    for (int s = 0; s < 8; s++) begin
`ifdef UART_BAUD_FRAC_EN
      tbl[s] = STEP_W'(inc_of(baud_sel_t'(s), 64'(CLK_HZ), 64'(OVERSAMPLE), ACC_W));
`else
      tbl[s] = STEP_W'(div_of(baud_sel_t'(s), 64'(CLK_HZ), 64'(OVERSAMPLE)) - 64'd1);
`endif
    end
    return tbl;
  endfunction

  localparam step_tbl_t STEP_TBL = build_tbl();

  for (genvar s = 0; s < 8; s++) begin : g_chk
    localparam logic [63:0] DIV = div_of(baud_sel_t'(s), 64'(CLK_HZ), 64'(OVERSAMPLE));
    if (DIV < 64'd2) begin : g_lo
      $error("uart_baud_gen: divisor below 2 for select %0d", s);
    end
    if (DIV > (64'd1 << CNT_W)) begin : g_hi
      $error("uart_baud_gen: CNT_W too narrow for select %0d", s);
    end
  end
  if (OVERSAMPLE < 2) begin : g_ovs
    $error("uart_baud_gen: OVERSAMPLE must be >= 2");
  end
  if (ACC_W < 8 || ACC_W > 40) begin : g_acc
    $error("uart_baud_gen: ACC_W out of range 8..40");
  end

  baud_sel_t       sel_q, sel_d;
  logic [PH_W-1:0] ph_q, ph_d;
  logic            smp_q, smp_d, tx_q, tx_d;
  logic            chg, tick;

  assign chg = (bus.baud_select != sel_q);

  baud_tick_div #(.STEP_W(STEP_W)) u_div (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (chg),
    .run_i  (bus.enable),
    .step_i (STEP_TBL[sel_q]),
    .tick_o (tick)
  );

  // bit_phase advances in the cycle the strobe is visible, so a tx strobe sees PH_LAST.
  always_comb begin
    sel_d = bus.baud_select;
    ph_d  = ph_q;
    smp_d = tick;
    tx_d  = tick && (ph_q == PH_LAST);
    if (chg || !bus.enable) begin
      ph_d  = '0;
      smp_d = 1'b0;
      tx_d  = 1'b0;
    end else if (smp_q) begin
      ph_d = (ph_q == PH_LAST) ? '0 : ph_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_q <= '0;
      ph_q  <= '0;
      smp_q <= 1'b0;
      tx_q  <= 1'b0;
    end else begin
      sel_q <= sel_d;
      ph_q  <= ph_d;
      smp_q <= smp_d;
      tx_q  <= tx_d;
    end
  end

  assign bus.sample_ENABLE = smp_q;
  assign bus.tx_ENABLE     = tx_q;
  assign bus.bit_phase     = ph_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen with a per-cycle reference model feeding a scoreboard queue.
module tb_uart_baud_gen;
  import uart_baud_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  uart_baud_gen_if #(.OVERSAMPLE(16)) bus ();

  uart_baud_gen #(
    .CLK_HZ(100_000_000), .OVERSAMPLE(16), .CNT_W(16), .ACC_W(24)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  logic       cur_r, cur_e;
  logic [2:0] cur_s;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_miss++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

`ifndef UART_BAUD_FRAC_EN
  localparam int DIV_TBL [8] = '{20833, 5208, 1302, 651, 326, 163, 109, 54};

  typedef struct packed { logic s; logic t; logic [3:0] ph; } exp_t;
  exp_t sb[$];

  int         m_cnt, m_ph;
  logic [2:0] m_sel;
  logic       m_s, m_t;

  // Reference model: register values the DUT must hold after the coming edge.
  task automatic model_next();
    logic tk;
    if (cur_r) begin
      m_sel = 3'd0; m_cnt = 0; m_ph = 0; m_s = 1'b0; m_t = 1'b0;
    end else if (cur_s != m_sel) begin
      m_sel = cur_s; m_cnt = 0; m_ph = 0; m_s = 1'b0; m_t = 1'b0;
    end else if (!cur_e) begin
      m_cnt = 0; m_ph = 0; m_s = 1'b0; m_t = 1'b0;
    end else begin
      tk    = (m_cnt == DIV_TBL[m_sel] - 1);
      m_t   = tk && (m_ph == 15);
      if (m_s) m_ph = (m_ph + 1) % 16;
      m_s   = tk;
      m_cnt = tk ? 0 : m_cnt + 1;
    end
  endtask
`endif

  task automatic step();
`ifndef UART_BAUD_FRAC_EN
    exp_t ex;
`endif
    reset           = cur_r;
    bus.enable      = cur_e;
    bus.baud_select = cur_s;
`ifndef UART_BAUD_FRAC_EN
    model_next();
    sb.push_back('{s: m_s, t: m_t, ph: 4'(m_ph)});
`endif
    @(posedge clk);
    #1;
    cyc++;
`ifndef UART_BAUD_FRAC_EN
    ex = sb.pop_front();
    chk("sample", 32'(bus.sample_ENABLE), 32'(ex.s));
    chk("tx", 32'(bus.tx_ENABLE), 32'(ex.t));
    chk("phase", 32'(bus.bit_phase), 32'(ex.ph));
`endif
  endtask

`ifndef UART_BAUD_FRAC_EN
  // Steps until sample_ENABLE is seen; w = number of edges taken.
  task automatic wait_pulse(input string tag, input int maxc, output int w);
    w = 0;
    do begin
      step();
      w++;
    end while (bus.sample_ENABLE !== 1'b1 && w < maxc);
    if (bus.sample_ENABLE !== 1'b1) chk({tag, "_timeout"}, 32'(bus.sample_ENABLE), 1);
  endtask
`endif

  initial begin
    #5_000_000;
    $display("FAIL watchdog: bench did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
`ifndef UART_BAUD_FRAC_EN
    int w, last_tx, n_tx, n_bad;

    // Reset held with sel=111; sel_q resets to 000, so the release cycle is a baud change
    // and the first strobe lands 1 + 54 edges after release.
    cur_r = 1'b1; cur_e = 1'b1; cur_s = 3'd7;
    repeat (5) step();
    chk("rst_smp", 32'(bus.sample_ENABLE), 0);
    chk("rst_tx", 32'(bus.tx_ENABLE), 0);
    chk("rst_ph", 32'(bus.bit_phase), 0);
    cur_r = 1'b0;
    wait_pulse("t1_first", 200, w);
    chk("t1_first", 32'(w), 55);
    repeat (2) begin
      wait_pulse("t1_gap", 200, w);
      chk("t1_gap", 32'(w), 54);
    end

    // Long run at 115200: tx every 16*54 cycles, on a sample strobe with phase 15.
    last_tx = -1; n_tx = 0;
    for (int i = 0; i < 2000; i++) begin
      step();
      if (bus.tx_ENABLE === 1'b1) begin
        chk("t2_tx_smp", 32'(bus.sample_ENABLE), 1);
        chk("t2_tx_ph", 32'(bus.bit_phase), 15);
        if (last_tx >= 0) chk("t2_tx_gap", 32'(cyc - last_tx), 864);
        last_tx = cyc;
        n_tx++;
      end
    end
    chk("t2_ntx", 32'(n_tx >= 2), 1);

    // Switch to 57600 with div_cnt at 30: change edge + 109 edges, phase restarts.
    wait_pulse("t3_sync", 200, w);
    repeat (30) step();
    cur_s = 3'd6;
    wait_pulse("t3_first", 300, w);
    chk("t3_first", 32'(w), 110);
    chk("t3_ph0", 32'(bus.bit_phase), 0);
    wait_pulse("t3_gap", 300, w);
    chk("t3_gap", 32'(w), 109);
    chk("t3_ph1", 32'(bus.bit_phase), 1);

    // Back to 115200, then disable mid-count for 200 cycles.
    cur_s = 3'd7;
    wait_pulse("t4_sync", 300, w);
    chk("t4_sync", 32'(w), 55);
    repeat (20) step();
    cur_e = 1'b0; n_bad = 0;
    repeat (200) begin
      step();
      if (bus.sample_ENABLE !== 1'b0 || bus.tx_ENABLE !== 1'b0) n_bad++;
    end
    chk("t4_quiet", 32'(n_bad), 0);
    cur_e = 1'b1;
    wait_pulse("t4_first", 200, w);
    chk("t4_first", 32'(w), 54);
    chk("t4_ph0", 32'(bus.bit_phase), 0);

    // One-cycle reset while bit_phase is 7.
    w = 0;
    while (bus.bit_phase !== 4'd7 && w < 2000) begin
      step();
      w++;
    end
    chk("t5_ph7", 32'(bus.bit_phase), 7);
    cur_r = 1'b1;
    step();
    chk("t5_smp0", 32'(bus.sample_ENABLE), 0);
    chk("t5_ph0", 32'(bus.bit_phase), 0);
    cur_r = 1'b0;
    wait_pulse("t5_first", 200, w);
    chk("t5_first", 32'(w), 55);

    // 38400 baud divisor.
    cur_s = 3'd5;
    wait_pulse("t6_first", 400, w);
    chk("t6_first", 32'(w), 164);
    wait_pulse("t6_gap", 400, w);
    chk("t6_gap", 32'(w), 163);
`else
    int n, last;

    cur_r = 1'b1; cur_e = 1'b1; cur_s = 3'd7;
    repeat (5) step();
    chk("f_rst_smp", 32'(bus.sample_ENABLE), 0);
    chk("f_rst_tx", 32'(bus.tx_ENABLE), 0);
    chk("f_rst_ph", 32'(bus.bit_phase), 0);
    cur_r = 1'b0;
    n = 0; last = -1;
    for (int i = 0; i < 60_000; i++) begin
      step();
      if (bus.sample_ENABLE === 1'b1) begin
        if (last >= 0) chk("f_gap", 32'((cyc - last) == 54 || (cyc - last) == 55), 1);
        last = cyc;
        n++;
      end
    end
    // 60000 * 1843200 / 1e8 = 1105.92
    chk("f_cnt_lo", 32'(n >= 1105), 1);
    chk("f_cnt_hi", 32'(n <= 1107), 1);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
